// File: rtl/accum_host_if.sv
// ============================================================================
// accum_host_if : host-side load / run / unload sequencer for the accumulator
// Rev 1.0
// ============================================================================
`default_nettype none

module accum_host_if #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 16,
  parameter int RESULT_ADDR = 31,
  parameter int TIMEOUT     = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              core_reset,
  input  logic              core_ready,
  output logic              mem_owner,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              result_valid,
  output logic [DATA_W-1:0] result_data,
  input  logic              result_ready,
  output logic [ADDR_W:0]   load_count,
  output logic              done,
  output logic              error
);

  localparam int RUN_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_READ = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   load_count_q, load_count_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic              result_valid_q, result_valid_d;
  logic [DATA_W-1:0] result_data_q, result_data_d;
  logic              error_q, error_d;

  logic w_beat;
  logic w_load_end;
  logic w_core_done;
  logic w_timeout;
  logic w_handshake;

  assign w_beat      = (state_q == ST_LOAD) && s_valid;
  assign w_load_end  = w_beat && (s_last || (wr_ptr_q == {ADDR_W{1'b1}}));
  // First RUN cycle has run_cnt_q == 0; the core is still leaving reset then.
  assign w_core_done = (state_q == ST_RUN) && core_ready && (run_cnt_q != '0);
  assign w_timeout   = (state_q == ST_RUN) && !w_core_done &&
                       (run_cnt_q == RUN_W'(TIMEOUT - 1));
  assign w_handshake = (state_q == ST_RESP) && result_valid_q && result_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      load_count_q   <= '0;
      run_cnt_q      <= '0;
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      load_count_q   <= load_count_d;
      run_cnt_q      <= run_cnt_d;
      result_valid_q <= result_valid_d;
      result_data_q  <= result_data_d;
      error_q        <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: if (w_load_end) state_d = ST_RUN;
      ST_RUN: begin
        if (w_core_done)    state_d = ST_READ;
        else if (w_timeout) state_d = ST_IDLE;
      end
      ST_READ: state_d = ST_RESP;
      ST_RESP: if (w_handshake) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    load_count_d   = load_count_q;
    run_cnt_d      = '0;
    result_valid_d = result_valid_q;
    result_data_d  = result_data_q;
    error_d        = error_q;

    if ((state_q == ST_IDLE) && start) begin
      wr_ptr_d = '0;
      error_d  = 1'b0;
    end
    if (w_beat) begin
      wr_ptr_d     = wr_ptr_q + 1'b1;
      load_count_d = {1'b0, wr_ptr_q} + 1'b1;
    end
    if (state_q == ST_RUN) begin
      run_cnt_d = (run_cnt_q == RUN_W'(TIMEOUT)) ? run_cnt_q : run_cnt_q + 1'b1;
    end
    if (w_timeout) error_d = 1'b1;
    // Memory data lands in the first RESP cycle, one cycle after the read strobe.
    if ((state_q == ST_RESP) && !result_valid_q) begin
      result_valid_d = 1'b1;
      result_data_d  = mem_data_out;
    end
    if (w_handshake) result_valid_d = 1'b0;
  end

  always_comb begin
    s_ready          = 1'b0;
    core_reset       = 1'b1;
    mem_owner        = 1'b0;
    mem_address      = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    mem_data_in      = '0;
    done             = 1'b0;
    case (state_q)
      ST_LOAD: begin
        s_ready          = 1'b1;
        mem_address      = wr_ptr_q;
        mem_data_in      = s_data;
        mem_write_enable = s_valid;
      end
      ST_RUN: begin
        core_reset = 1'b0;
        mem_owner  = 1'b1;
      end
      ST_READ: begin
        mem_read_enable = 1'b1;
        mem_address     = ADDR_W'(RESULT_ADDR);
      end
      ST_RESP: done = w_handshake;
      default: ;
    endcase
  end

  assign result_valid = result_valid_q;
  assign result_data  = result_data_q;
  assign load_count   = load_count_q;
  assign error        = error_q;

endmodule

`default_nettype wire

// File: tb/tb_accum_host_if.sv
// ============================================================================
// tb_accum_host_if : directed bench with a cycle-window model of the sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_accum_host_if;

  localparam int ADDR_W      = 5;
  localparam int DATA_W      = 16;
  localparam int RESULT_ADDR = 31;
  localparam int TIMEOUT     = 1023;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;
  logic              core_reset;
  logic              core_ready;
  logic              mem_owner;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_write_enable;
  logic              mem_read_enable;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              result_valid;
  logic [DATA_W-1:0] result_data;
  logic              result_ready;
  logic [ADDR_W:0]   load_count;
  logic              done;
  logic              error;

  always #5 clk = ~clk;

  accum_host_if #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESULT_ADDR(RESULT_ADDR), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .core_reset(core_reset), .core_ready(core_ready),
    .mem_owner(mem_owner), .mem_address(mem_address),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .result_valid(result_valid), .result_data(result_data), .result_ready(result_ready),
    .load_count(load_count), .done(done), .error(error)
  );

  // Memory plus a stand-in core that writes the sum of the loaded words to the
  // result address on its first running cycle and raises ready after a delay.
  logic [DATA_W-1:0] mem [0:31];
  int                core_age = 0;
  int                core_delay = 1;
  logic [DATA_W-1:0] core_sum = '0;

  assign core_ready = !core_reset && (core_age >= core_delay);

  always @(posedge clk) begin
    core_age <= core_reset ? 0 : core_age + 1;
    if (!core_reset && core_age == 0) mem[RESULT_ADDR] <= core_sum;
    else if (!mem_owner && mem_write_enable) mem[mem_address] <= mem_data_in;
    if (mem_read_enable) mem_data_out <= mem[mem_address];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected behaviour of the current transaction as cycle windows.
  int load_first = -1, load_last = -2;
  int run_first = -1, run_last = -2;
  int read_cyc = -1, rv_first = -1, hs_cyc = -2, err_set_cyc = -1;
  logic [DATA_W-1:0] exp_sum = '0;
  int                wq_cyc[$];
  logic [ADDR_W-1:0] wq_addr[$];
  logic [DATA_W-1:0] wq_data[$];
  int   exp_lc = 0;
  bit   exp_err = 1'b0;
  int   nchk = 0, nfail = 0;
  int   done_cnt = 0;
  logic [DATA_W-1:0] last_result = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    int c;
    bit in_run, exp_we, in_rv;
    c = cyc;
    if (!reset) begin
      exp_lc  = 0;
      exp_err = 1'b0;
      chk("rst_mem_address", mem_address, 0);
      chk("rst_mem_data_in", mem_data_in, 0);
    end
    in_run = (c >= run_first) && (c <= run_last);
    in_rv  = (c >= rv_first) && (c <= hs_cyc);
    chk("s_ready", s_ready, (c >= load_first) && (c <= load_last));
    chk("core_reset", core_reset, !in_run);
    chk("mem_owner", mem_owner, in_run);
    chk("mem_read_enable", mem_read_enable, c == read_cyc);
    if (c == read_cyc) chk("read_address", mem_address, RESULT_ADDR);
    exp_we = (wq_cyc.size() > 0) && (wq_cyc[0] == c);
    chk("mem_write_enable", mem_write_enable, exp_we);
    chk("load_count", load_count, exp_lc);
    if (exp_we) begin
      chk("write_address", mem_address, wq_addr[0]);
      chk("write_data", mem_data_in, wq_data[0]);
      exp_lc = wq_addr[0] + 1;
      void'(wq_cyc.pop_front());
      void'(wq_addr.pop_front());
      void'(wq_data.pop_front());
    end
    chk("result_valid", result_valid, in_rv);
    if (in_rv) chk("result_data", result_data, exp_sum);
    chk("done", done, c == hs_cyc);
    if (c == err_set_cyc) exp_err = 1'b1;
    if (c == load_first)  exp_err = 1'b0;
    chk("error", error, exp_err);
    if (done) begin
      done_cnt++;
      last_result = result_data;
    end
  end

  bit                vpat[40];
  logic [DATA_W-1:0] dpat[40];
  bit                lpat[40];
  int                plen;

  task automatic setpat(input int i, input bit v, input logic [DATA_W-1:0] d, input bit l);
    vpat[i] = v;
    dpat[i] = d;
    lpat[i] = l;
    if (i + 1 > plen) plen = i + 1;
  endtask

  // rst_off >= 0 drops reset that many beat-cycles into the load phase.
  task automatic txn(input int delay, input int bp, input bit rr_early, input int rst_off);
    int s, k, n, m, rst_c, endc, rr_from;
    bit ended;
    logic [DATA_W-1:0] sum;
    @(posedge clk); #1;
    s      = cyc;
    rst_c  = (rst_off >= 0) ? s + 1 + rst_off : -1;
    k      = 0;
    n      = -1;
    ended  = 1'b0;
    sum    = '0;
    for (int i = 0; i < plen && !ended; i++) begin
      if (s + 1 + i == rst_c) begin
        ended = 1'b1;
      end else if (vpat[i]) begin
        wq_cyc.push_back(s + 1 + i);
        wq_addr.push_back(ADDR_W'(k));
        wq_data.push_back(dpat[i]);
        sum = sum + dpat[i];
        k++;
        if (lpat[i] || k == 32) begin
          n     = s + 1 + i;
          ended = 1'b1;
        end
      end
    end
    load_first  = s + 1;
    err_set_cyc = -1;
    read_cyc    = -1;
    rv_first    = -1;
    hs_cyc      = -2;
    if (rst_c >= 0) begin
      load_last = rst_c - 1;
      run_first = -1;
      run_last  = -2;
      endc      = rst_c + 3;
    end else begin
      load_last = n;
      run_first = n + 1;
      m = run_first + ((delay > 1) ? delay : 1);
      if (m > run_first + TIMEOUT - 1) begin
        run_last    = run_first + TIMEOUT - 1;
        err_set_cyc = run_last + 1;
        endc        = run_last + 3;
      end else begin
        run_last = m;
        read_cyc = m + 1;
        rv_first = m + 3;
        hs_cyc   = rv_first + bp;
        endc     = hs_cyc + 2;
      end
    end
    rr_from    = rr_early ? read_cyc : hs_cyc;
    exp_sum    = sum;
    core_sum   = sum;
    core_delay = delay;
    done_cnt   = 0;
    start        = 1'b1;
    s_valid      = 1'b0;
    result_ready = 1'b0;
    for (int c = s + 1; c <= endc; c++) begin
      int i;
      @(posedge clk); #1;
      i = c - (s + 1);
      start        = (c == s + 2);
      s_valid      = (i < plen) ? vpat[i] : 1'b0;
      s_data       = (i < plen) ? dpat[i] : '0;
      s_last       = (i < plen) ? lpat[i] : 1'b0;
      reset        = (c == rst_c) ? 1'b0 : 1'b1;
      result_ready = (c >= rr_from) && (c <= hs_cyc);
    end
    start        = 1'b0;
    s_valid      = 1'b0;
    s_last       = 1'b0;
    result_ready = 1'b0;
    plen         = 0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    result_ready = 1'b0; plen = 0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Reset dropped after three accepted words.
    for (int i = 0; i < 5; i++) setpat(i, 1'b1, 16'h00A1 + 16'(i), 1'b0);
    txn(1, 0, 1'b0, 3);
    chk("lit_reset_load_count", load_count, 0);
    chk("lit_reset_core_reset", core_reset, 1);

    // Normal: 1+2+3+4 = 0x000A.
    for (int i = 0; i < 4; i++) setpat(i, 1'b1, 16'(i + 1), i == 3);
    txn(1, 0, 1'b0, -1);
    chk("lit_normal_result", last_result, 16'h000A);
    chk("lit_normal_done_count", done_cnt, 1);
    chk("lit_normal_load_count", load_count, 4);

    // Host stalls, ready high from cycle 0 of RUN, result_ready raised early.
    setpat(0, 1'b1, 16'h0011, 1'b0);
    setpat(1, 1'b0, 16'hDEAD, 1'b0);
    setpat(2, 1'b0, 16'hBEEF, 1'b0);
    setpat(3, 1'b1, 16'h0022, 1'b0);
    setpat(4, 1'b1, 16'h0033, 1'b1);
    txn(0, 0, 1'b1, -1);
    chk("lit_stall_result", last_result, 16'h0066);
    chk("lit_stall_load_count", load_count, 3);

    // Full depth: 33 valid beats, no s_last; sum of 1..32 = 0x0210.
    for (int i = 0; i < 33; i++) setpat(i, 1'b1, (i < 32) ? 16'(i + 1) : 16'h0100, 1'b0);
    txn(3, 0, 1'b0, -1);
    chk("lit_full_load_count", load_count, 32);
    chk("lit_full_result", last_result, 16'h0210);

    // Back-pressure for 10 cycles.
    setpat(0, 1'b1, 16'h1234, 1'b0);
    setpat(1, 1'b1, 16'h0101, 1'b1);
    txn(2, 10, 1'b0, -1);
    chk("lit_bp_result", last_result, 16'h1335);
    chk("lit_bp_done_count", done_cnt, 1);

    // Timeout: core never ready.
    setpat(0, 1'b1, 16'h0007, 1'b1);
    txn(5000, 0, 1'b0, -1);
    chk("lit_timeout_error", error, 1);
    chk("lit_timeout_done_count", done_cnt, 0);

    // Next start clears error.
    setpat(0, 1'b1, 16'h0005, 1'b0);
    setpat(1, 1'b1, 16'h0006, 1'b1);
    txn(1, 0, 1'b0, -1);
    chk("lit_after_timeout_error", error, 0);
    chk("lit_after_timeout_result", last_result, 16'h000B);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

`default_nettype wire
